// File: rtl/sr64_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sr64_seq_ctrl
//   Sequencer for one sr64 universal shift register. A request carries a word
//   and a shift length. The controller parallel-loads the word, issues the
//   requested number of right shifts with ser_in entering the top bit, and then
//   returns the register contents on a valid/ready response channel.
//
//   Build option:
//     SR64_CTRL_ABORT_EN  adds an 'abort' input. Asserting it while in LOAD or
//                         SHIFT suppresses that cycle's load/shift and returns
//                         the controller to IDLE without a response.
//
//   Ports:
//     clock        rising-edge clock
//     reset        asynchronous active-low reset
//     abort        (SR64_CTRL_ABORT_EN only) cancel current load/shift
//     req_valid    request present
//     req_ready    controller can accept a request (IDLE only)
//     req_data     word to parallel-load
//     req_len      number of shifts after the load (values > N clamp to N)
//     ser_in       serial bit forwarded to the register during shifts
//     rsp_valid    result available
//     rsp_ready    master accepts result
//     rsp_data     register contents after the last shift
//     busy         high in every state except IDLE
//     sr_par_in    to sr64 par_in (holds last latched word)
//     sr_load      to sr64 load
//     sr_mode      to sr64 mode (1 = shift right)
//     sr_serin     to sr64 serin
//     sr_data_out  from sr64 Data_out
// -----------------------------------------------------------------------------
module sr64_seq_ctrl #(
    parameter int N     = 64,
    parameter int CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset,
`ifdef SR64_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_data,
    input  logic [CNT_W-1:0] req_len,
    input  logic             ser_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             busy,
    output logic [N-1:0]     sr_par_in,
    output logic             sr_load,
    output logic             sr_mode,
    output logic             sr_serin,
    input  logic [N-1:0]     sr_data_out
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N-1:0]     par_r;
    logic             req_ready_r;
    logic             busy_r;
    logic             rsp_valid_r;
    logic             load_r;
    logic             mode_r;
    logic             abort_s;
    logic [CNT_W-1:0] len_clamped_s;

`ifdef SR64_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Clamp the requested length so a transaction never shifts more than N times.
    always_comb begin
        len_clamped_s = req_len;
        if (req_len > LEN_MAX) begin
            len_clamped_s = LEN_MAX;
        end else begin
            len_clamped_s = req_len;
        end
    end

    // Main sequencer: state, counter, latched word and registered strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            par_r       <= {N{1'b0}};
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            load_r      <= 1'b0;
            mode_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        state_r     <= ST_LOAD;
                        par_r       <= req_data;
                        cnt_r       <= len_clamped_s;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        load_r      <= 1'b1;
                    end else begin
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        load_r      <= 1'b0;
                        mode_r      <= 1'b0;
                        rsp_valid_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    load_r <= 1'b0;
                    if (abort_s) begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= {CNT_W{1'b0}};
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (cnt_r != {CNT_W{1'b0}}) begin
                        state_r <= ST_SHIFT;
                        mode_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Counter holds the shifts still to issue, including this one.
                    if (abort_s) begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= {CNT_W{1'b0}};
                        mode_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (cnt_r <= CNT_ONE) begin
                        state_r     <= ST_RESP;
                        cnt_r       <= {CNT_W{1'b0}};
                        mode_r      <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    load_r      <= 1'b0;
                    mode_r      <= 1'b0;
                end
            endcase
        end
    end

    // The register holds in RESP, so its output can be presented directly.
    assign rsp_data  = rsp_valid_r ? sr_data_out : {N{1'b0}};
    assign rsp_valid = rsp_valid_r;
    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign sr_par_in = par_r;
    // Abort must suppress the strobe in the very cycle it is raised.
    assign sr_load   = load_r & ~abort_s;
    assign sr_mode   = mode_r & ~abort_s;
    assign sr_serin  = mode_r & ser_in;

endmodule

// File: doc/sr64_seq_ctrl.md
# sr64_seq_ctrl

Sequencer for the 64-bit universal shift register (`sr64`). It accepts a word and a shift length over a valid/ready request channel, then parallel-loads the register and issues the requested number of serial shifts with `ser_in` fed in. It returns the final register contents over a valid/ready response channel. It sits between a requesting master and one `sr64` instance and is the only driver of that instance's `par_in`, `load`, `mode` and `serin`.

## Interface
- `N`, default 64: datapath width, equal to the `sr64` width.
- `CNT_W`, default 7: width of `req_len` and of the internal shift counter; must satisfy 2^CNT_W > N.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request.
- `req_data`  in  N: word to parallel-load.
- `req_len`  in  CNT_W: number of shifts after the load.
- `ser_in`  in  1: serial bit, passed to `sr64` during shifts.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: master accepts result.
- `rsp_data`  out  N: register contents after the last shift.
- `busy`  out  1: high in every state except IDLE.
- `sr_par_in`  out  N: to `sr64` `par_in`.
- `sr_load`  out  1: to `sr64` `load`.
- `sr_mode`  out  1: to `sr64` `mode`.
- `sr_serin`  out  1: to `sr64` `serin`.
- `sr_data_out`  in  N: from `sr64` `Data_out`.

## Operation
- Datapath contract: `load`=1 loads `par_in`. `load`=0 with `mode`=1 shifts right by one, with `serin` entering bit N-1. `load`=0 with `mode`=0 holds.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_data` into `sr_par_in` and latch the length, then go to LOAD.
  - Length clamp: `req_len` > N is stored as N.
- **LOAD** (one cycle)
  - `sr_load`=1 and `sr_mode`=0.
  - Next state is SHIFT if the stored length is nonzero, otherwise RESP.
- **SHIFT**
  - `sr_load`=0, `sr_mode`=1, `sr_serin`=`ser_in`.
  - The counter decrements each cycle.
  - Go to RESP in the cycle the counter reaches 1.
- **RESP**
  - `sr_mode`=0, so the register holds.
  - `rsp_valid`=1 and `rsp_data`=`sr_data_out`.
  - On `rsp_ready`, go to IDLE.
- Outputs driven as 0 outside their active state: `sr_load`, `sr_mode`, `sr_serin`, `rsp_valid`.
- `sr_par_in` keeps the last latched word.
- `busy` is 0 only in IDLE.
- In RESP, requests are not accepted (`req_ready`=0). There is no overlap between transactions.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE.
  - `req_ready`=1, `busy`=0.
  - `rsp_valid`=0, `sr_load`=0, `sr_mode`=0, `sr_serin`=0.
  - `sr_par_in`=0 and the counter is 0.
- Reset asserted mid-transaction aborts it immediately. No response is issued.
- Request accepted at edge T:
  - LOAD during cycle T+1.
  - SHIFT during cycles T+2 .. T+1+L, where L is the clamped length.
  - `rsp_valid` rises at T+2+L; for L=0 this is T+2.
- Exactly L shift cycles occur, and exactly one load per transaction.
- `rsp_valid` stays high, with `rsp_data` stable, until accepted. Acceptance edge R gives `req_ready`=1 from R+1 onward.
- Minimum request-to-request spacing: L+3 cycles when `rsp_ready` is held high.

## Configuration
- `SR64_CTRL_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in LOAD or SHIFT forces `sr_mode`=0 and `sr_load`=0 that cycle, and the state goes to IDLE on the next edge. No response is issued.
  - `abort` is ignored in IDLE and RESP.
- `SR64_CTRL_ABORT_EN` undefined: the port is absent and every accepted request completes.

## Test plan
- Load-only:
  - Stimulus: `req_data`=64'h0000_0001_0000_0000, `req_len`=0.
  - Response: one `sr_load` pulse, no `sr_mode` pulse, `rsp_valid` at T+2, `rsp_data`=64'h0000_0001_0000_0000.
- Shift with zeros:
  - Stimulus: same word, `req_len`=4, `ser_in`=0.
  - Response: exactly 4 `sr_mode` cycles, `rsp_data`=64'h0000_0000_1000_0000, `rsp_valid` at T+6.
- Shift with ones and clamp:
  - Stimulus: `req_data`=0, `req_len`=100, `ser_in`=1.
  - Response: clamped to 64 shifts, `rsp_data`=64'hFFFF_FFFF_FFFF_FFFF, `rsp_valid` at T+66.
- Response backpressure:
  - Stimulus: `rsp_ready`=0 for 10 cycles while `req_valid` is held.
  - Response: `rsp_valid` and `rsp_data` stable, `req_ready`=0 and no new load. After `rsp_ready`=1, `req_ready` rises the next cycle.
- Reset mid-shift:
  - Stimulus: `reset`=0 during the 3rd shift of an 8-shift request.
  - Response: all outputs take their reset values immediately, no `rsp_valid`, and the next request completes normally.
- Abort (with `SR64_CTRL_ABORT_EN` defined):
  - Stimulus: `abort` pulse in the 2nd SHIFT cycle.
  - Response: `sr_mode`=0 that cycle, IDLE next, `rsp_valid` never asserted.
